// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - preset/control inputs and BCD display outputs of the countdown timer
interface countdown_timer_if;
  logic [3:0] init_val1;
  logic [3:0] init_val0;
  logic       load;
  logic       start_pause;
  logic [3:0] digit1;
  logic [3:0] digit0;
  logic       running;
  logic       sec_tick;
  logic       done;

  modport master (
    output init_val1, init_val0, load, start_pause,
    input  digit1, digit0, running, sec_tick, done
  );

  modport slave (
    input  init_val1, init_val0, load, start_pause,
    output digit1, digit0, running, sec_tick, done
  );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - two-digit BCD countdown timer with prescaler and IDLE/RUN/PAUSE/DONE control
module countdown_timer #(
  parameter int TICK_DIV = 100000000
) (
  input  logic               clk,
  input  logic               rst,
  countdown_timer_if.slave   tmr
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    d1_q, d1_d;
  logic [3:0]    d0_q, d0_d;
  logic          tick_q, tick_d;
  logic          running_q, done_q;
  logic [3:0]    pre1, pre0;
  logic          wrap;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  always_comb begin
    pre1 = clamp_bcd(tmr.init_val1);
    pre0 = clamp_bcd(tmr.init_val0);
    // A 00 preset means a full minute
    if (pre1 == 4'd0 && pre0 == 4'd0) begin
      pre1 = 4'd6;
    end
  end

  assign wrap = (presc_q == PRESC_LAST);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    d1_d    = d1_q;
    d0_d    = d0_q;
    tick_d  = 1'b0;
    if (tmr.load) begin
      state_d = IDLE;
      presc_d = '0;
      d1_d    = pre1;
      d0_d    = pre0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tmr.start_pause && (d1_q != 4'd0 || d0_q != 4'd0)) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (tmr.start_pause) begin
            state_d = PAUSE;
          end
          if (wrap) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (d0_q != 4'd0) begin
              d0_d = d0_q - 4'd1;
            end else begin
              d0_d = 4'd9;
              d1_d = d1_q - 4'd1;
            end
            // Reaching zero overrides a same-cycle pause request
            if (d1_q == 4'd0 && d0_q == 4'd1) begin
              state_d = DONE;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
        PAUSE: begin
          if (tmr.start_pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      d1_q      <= 4'd0;
      d0_q      <= 4'd0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      d1_q      <= d1_d;
      d0_q      <= d0_d;
      tick_q    <= tick_d;
      running_q <= (state_d == RUN);
      done_q    <= (state_d == DONE);
    end
  end

  assign tmr.digit1   = d1_q;
  assign tmr.digit0   = d0_q;
  assign tmr.running  = running_q;
  assign tmr.sec_tick = tick_q;
  assign tmr.done     = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed scoreboard bench for countdown_timer with TICK_DIV=4
module tb_countdown_timer;
  localparam int TD = 4;

  logic clk;
  logic rst;
  countdown_timer_if tif();

  countdown_timer #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model keeps remaining time as an integer number of seconds
  int m_sec   = 0;
  int m_state = 0; // 0 idle, 1 run, 2 pause, 3 done
  int m_pre   = 0;
  bit m_tick  = 0;

  logic [10:0] exp_q[$];

  function automatic logic [10:0] model_out();
    logic [3:0] t, o;
    t = 4'(m_sec / 10);
    o = 4'(m_sec % 10);
    return {t, o, (m_state == 1), m_tick, (m_state == 3)};
  endfunction

  function automatic int clampi(input logic [3:0] v);
    return (v > 4'd9) ? 9 : int'(v);
  endfunction

  task automatic model_step(input bit r, input bit ld, input bit sp);
    if (r) begin
      m_sec = 0; m_state = 0; m_pre = 0; m_tick = 0;
    end else if (ld) begin
      m_sec = clampi(tif.init_val1) * 10 + clampi(tif.init_val0);
      if (m_sec == 0) m_sec = 60;
      m_state = 0; m_pre = 0; m_tick = 0;
    end else begin
      m_tick = 0;
      case (m_state)
        0: if (sp && m_sec != 0) begin m_state = 1; m_pre = 0; end
        1: begin
          if (sp) m_state = 2;
          if (m_pre == TD - 1) begin
            m_pre = 0;
            m_tick = 1;
            m_sec = m_sec - 1;
            if (m_sec == 0) m_state = 3;
          end else begin
            m_pre = m_pre + 1;
          end
        end
        2: if (sp) m_state = 1;
        default: ;
      endcase
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit ld, input bit sp);
    logic [10:0] e;
    rst = r;
    tif.load = ld;
    tif.start_pause = sp;
    model_step(r, ld, sp);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
    rst = 1'b0;
    tif.load = 1'b0;
    tif.start_pause = 1'b0;
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("outputs", {21'd0, tif.digit1, tif.digit0, tif.running, tif.sec_tick, tif.done},
            {21'd0, e});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic preset(input logic [3:0] a, input logic [3:0] b);
    tif.init_val1 = a;
    tif.init_val0 = b;
  endtask

  initial begin
    rst = 1'b1;
    tif.load = 1'b0;
    tif.start_pause = 1'b0;
    preset(4'd0, 4'd0);
    #1;

    step(1, 0, 0);
    check("reset_state", {tif.digit1, tif.digit0, tif.running, tif.done, tif.sec_tick}, 11'd0);
    step(0, 0, 1);
    check("start_without_load", {tif.digit1, tif.digit0, tif.running}, 9'd0);

    // 30 -> 29 exactly TICK_DIV cycles after start
    preset(4'd3, 4'd0);
    step(0, 1, 0);
    check("load_30", {tif.digit1, tif.digit0}, 8'h30);
    step(0, 0, 1);
    idle(3);
    check("before_first_tick", {tif.digit1, tif.digit0, tif.sec_tick}, {8'h30, 1'b0});
    idle(1);
    check("first_tick", {tif.digit1, tif.digit0, tif.sec_tick, tif.running}, {8'h29, 2'b11});
    idle(1);
    check("tick_one_cycle", 32'(tif.sec_tick), 32'd0);

    // Pause after two prescaler cycles, hold, resume
    step(0, 1, 0);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    idle(10);
    check("paused_hold", {tif.digit1, tif.digit0, tif.running}, {8'h30, 1'b0});
    step(0, 0, 1);
    idle(1);
    check("resume_no_tick_yet", {tif.digit1, tif.digit0}, 8'h30);
    idle(1);
    check("resume_tick", {tif.digit1, tif.digit0, tif.sec_tick}, {8'h29, 1'b1});

    // Preset changes without load are ignored; load beats start_pause
    preset(4'd5, 4'd7);
    idle(3);
    step(0, 1, 1);
    check("load_over_start", {tif.digit1, tif.digit0, tif.running}, {8'h57, 1'b0});
    idle(2);

    // Reset mid-run
    step(0, 0, 1);
    idle(6);
    step(1, 1, 1);
    check("rst_mid_run", {tif.digit1, tif.digit0, tif.running, tif.done}, 10'd0);
    step(0, 0, 1);
    idle(2);

    // Clamp and tens borrow
    preset(4'hF, 4'hC);
    step(0, 1, 0);
    check("clamp_99", {tif.digit1, tif.digit0}, 8'h99);
    preset(4'd1, 4'd0);
    step(0, 1, 0);
    step(0, 0, 1);
    idle(TD);
    check("borrow_09", {tif.digit1, tif.digit0}, 8'h09);

    // Pause requested on the tick that reaches zero: DONE wins
    preset(4'd0, 4'd1);
    step(0, 1, 0);
    step(0, 0, 1);
    idle(TD - 1);
    step(0, 0, 1);
    check("done_beats_pause", {tif.digit1, tif.digit0, tif.running, tif.done}, {8'h00, 2'b01});

    // 00 preset runs a full minute
    preset(4'd0, 4'd0);
    step(0, 1, 0);
    check("load_60", {tif.digit1, tif.digit0}, 8'h60);
    step(0, 0, 1);
    idle(60 * TD - 1);
    check("pre_done", {tif.digit1, tif.digit0, tif.done}, {8'h01, 1'b0});
    idle(1);
    check("done_60", {tif.digit1, tif.digit0, tif.done, tif.running}, {8'h00, 2'b10});
    step(0, 0, 1);
    idle(3);
    check("done_sticky", {tif.digit1, tif.digit0, tif.done, tif.sec_tick}, {8'h00, 2'b10});

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 100000000, meaning clk cycles per one-second decrement, legal range 2 and above.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high; clock clk.
REQ-004 The block SHALL have port init_val1  input  4  preset tens digit (BCD) from the mode selector.
REQ-005 The block SHALL have port init_val0  input  4  preset ones digit (BCD) from the mode selector.
REQ-006 The block SHALL have port load  input  1  single-cycle pulse: copy preset into the counter.
REQ-007 The block SHALL have port start_pause  input  1  single-cycle pulse: start, pause or resume counting.
REQ-008 The block SHALL have port digit1  output  4  current tens digit (BCD), registered.
REQ-009 The block SHALL have port digit0  output  4  current ones digit (BCD), registered.
REQ-010 The block SHALL have port running  output  1  high while in RUN.
REQ-011 The block SHALL have port sec_tick  output  1  one-cycle pulse on every decrement.
REQ-012 The block SHALL have port done  output  1  high while in DONE.

Function
REQ-013 The block SHALL implement four states: IDLE, RUN, PAUSE, DONE; running = (state==RUN), done = (state==DONE), both registered.
REQ-014 On load, from any state, the block SHALL enter IDLE, clear the prescaler, and set digits from init_val1/init_val0 on the next edge.
REQ-015 A preset of 00 SHALL load as 60 (digit1=6, digit0=0); the 00 preset is defined as 60 seconds.
REQ-016 Any preset digit above 9 SHALL be clamped to 9 on load.
REQ-017 load SHALL take priority over start_pause in the same cycle; start_pause that cycle is discarded.
REQ-018 In IDLE, start_pause SHALL move to RUN if digits are not 00; if digits are 00 it is ignored.
REQ-019 In RUN, the prescaler SHALL count 0..TICK_DIV-1; in the cycle it equals TICK_DIV-1 it wraps to 0, sec_tick=1 next cycle, and the digits decrement by one.
REQ-020 First decrement SHALL appear exactly TICK_DIV cycles after the edge that accepted start from IDLE.
REQ-021 BCD decrement: digit0>0 -> digit0-1; digit0==0 -> digit0=9, digit1-1; no non-BCD value SHALL ever appear on the outputs.
REQ-022 A decrement reaching 00 SHALL move to DONE on the same edge; running drops and done rises together with the digits becoming 00.
REQ-023 In RUN, start_pause SHALL move to PAUSE; if a decrement is due in that cycle it is still applied (and DONE wins if it reaches 00).
REQ-024 In PAUSE, the prescaler and digits SHALL hold; start_pause returns to RUN and the prescaler resumes from its held value.
REQ-025 In DONE, digits SHALL hold 00 and start_pause SHALL be ignored; exit only via load or rst.
REQ-026 sec_tick SHALL be 0 in every cycle not immediately following a prescaler wrap in RUN.
REQ-027 Preset inputs SHALL be sampled only on load; changes at other times have no effect.

Reset
REQ-028 With rst high at an edge, the block SHALL enter IDLE, clear the prescaler, and set digit1=0, digit0=0, running=0, done=0, sec_tick=0.
REQ-029 rst SHALL override load and start_pause in the same cycle, including mid-count in RUN or PAUSE.
REQ-030 After reset, start_pause without a prior load SHALL be ignored (digits 00).

Verification (TICK_DIV=4)
REQ-031 Preset 3/0, load, start_pause -> digits 30, then 29 exactly 4 cycles after start accepted, sec_tick one cycle, running=1.
REQ-032 Preset 0/0, load -> digits 60; run 60 ticks -> digits 00, done=1, running=0 on the 60th decrement; further start_pause keeps DONE.
REQ-033 Preset 1/0 run to 10 -> next tick gives 09 (ones wrap to 9, tens decrement); preset 0xF/0xC loads as 99.
REQ-034 Pause after 2 prescaler cycles, hold 10 cycles, resume -> digits unchanged while paused; next decrement 2 cycles after resume.
REQ-035 load and start_pause same cycle while in RUN -> IDLE with new preset, running=0; rst mid-RUN -> digits 00, IDLE, start_pause ignored.
